pri_sched: RTL
==============

# pri_sched

Arbitration-state stage that feeds the three-way priority selector in the DDR2 controller front end. It owns the requester ordering and the idle/busy handshake with the DDR2 command sequencer. It drives the selector's `pri` and `is_idle` inputs, and issues a one-cycle grant that is bit-exact with the selector's choice. A per-requester burst allowance keeps a winner at the head of the order for up to `BURST` consecutive grants (row-hit friendly) before rotating it to the tail.

## Interface
- `BURST`, 4: consecutive grants a requester may take before rotation to tail. Legal range 1..7; 1 gives pure least-recently-granted.
- `CNT_W`, 3: width of the run counter; must hold `BURST`.
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: reset, synchronous, active-low.
- `req1`, `req2`, `req3` in 1 each: request levels, also routed to the selector.
- `done` in 1: one-cycle pulse from the sequencer marking the end of the granted access.
- `pri` out 3: current order code. Encoding: 0=123, 1=132, 2=213, 3=231, 4=312, 5=321. Codes 6 and 7 are never driven.
- `is_idle` out 1: high in IDLE; the selector samples requests while this is high.
- `gnt` out 3: one-hot grant pulse, bit0=req1. Asserted the cycle after the decision edge.
- `err_done` out 1: sticky; set when `done` arrives in IDLE.

## Operation
- States: IDLE, BUSY. All outputs are registered.
- Reset values: state IDLE, `is_idle`=1, `pri`=0, `gnt`=0, `err_done`=0, run counter 0, last winner none.
- IDLE, any req high at edge:
  - Winner w = first requesting index in the current `pri` order.
  - State → BUSY; `gnt[w]`=1 for one cycle; order updated.
- IDLE, no req: hold; `gnt`=0.
- BUSY: `gnt`=0 and requests are ignored. When `done`=1, state → IDLE.
- Order update on grant to w:
  - n = (w == last) ? run+1 : 1.
  - If n ≥ BURST: move w to the tail, keep the other two in their relative order, run=0, last=none.
  - Else: move w to the head, keep the other two in their relative order, run=n, last=w.
- `done` in IDLE: ignored for state; `err_done` set and held until reset.
- `done` and req in the same BUSY cycle: return to IDLE only. The earliest next grant is the following edge.
- Reset low mid-BUSY: at the next edge, full reset values; a pending `done` is lost.
- Request deassertion never alters order or run count.

## Timing
- Decision edge E is the edge at which the selector also captures its value, using pre-update `pri`.
- At E+1: `gnt` valid, `is_idle`=0, `pri` shows the new order.
- `done` seen at edge D: at D+1, `is_idle`=1. A new decision is possible at edge D+1, giving `gnt` at D+2.
- Minimum grant-to-grant spacing is 2 cycles (done in the first BUSY cycle).

## Structure
- Shared package `pri_pkg` holds:
  - Order-code constants `P123`..`P321`, 3 bits, identical to the selector's encoding.
  - State enum.
  - Pure functions `pri_winner(code, req)`, `pri_to_head(code, idx)`, `pri_to_tail(code, idx)`.
- No sub-module; a single always block plus package functions.

## Test plan
- Reset, then req1=req2=req3=1 held; `done` pulsed the cycle after each grant; BURST=4:
  - `gnt` = 001 ×4, then 010 ×4, then 100 ×4.
  - `pri` after the 4th grant to 1 is 3 (231); after the 4th grant to 2 it is 4 (312).
- BURST=1, all reqs held, `done` each BUSY cycle:
  - `gnt` sequence 001, 010, 100, 001.
  - `pri` sequence 3, 4, 0, 3.
- BURST=4, only req2 high from reset:
  - `gnt`=010 at E+1 and `pri`=2 (213).
  - Then req1 rises: the next grant goes to 2 (run=2), not 1.
- `done` pulse while `is_idle`=1 and no reqs:
  - `err_done`=1 the next cycle and stays 1 until `RST`=0.
- req1 held, `done` and req3 together in BUSY:
  - `is_idle`=1 the next cycle, then `gnt`=001 one cycle later.
- `RST`=0 for one cycle in BUSY with pri=4:
  - Next cycle `is_idle`=1, `pri`=0, `gnt`=0.
  - A subsequent `done` sets `err_done`.

Source files
------------

// File: rtl/pri_pkg.sv
// pri_pkg: order codes, FSM states and order-manipulation helpers shared with the priority selector.
package pri_pkg;
  localparam logic [2:0] P123 = 3'd0;
  localparam logic [2:0] P132 = 3'd1;
  localparam logic [2:0] P213 = 3'd2;
  localparam logic [2:0] P231 = 3'd3;
  localparam logic [2:0] P312 = 3'd4;
  localparam logic [2:0] P321 = 3'd5;
  localparam logic [1:0] NONE = 2'd3;
  typedef enum logic {ST_IDLE, ST_BUSY} state_t;
  // Unpack a code into {third, second, first}, each a 0-based requester index.
  function automatic logic [5:0] pri_order(input logic [2:0] code);
    logic [1:0] f, lo, hi;
    f = code[2:1];
    lo = (f == 2'd0) ? 2'd1 : 2'd0;
    hi = (f == 2'd2) ? 2'd1 : 2'd2;
    return code[0] ? {lo, hi, f} : {hi, lo, f};
  endfunction
  function automatic logic [2:0] pri_encode(input logic [1:0] f, input logic [1:0] s, input logic [1:0] t);
    return {f, s > t};
  endfunction
  function automatic logic [1:0] pri_winner(input logic [2:0] code, input logic [2:0] req);
    logic [5:0] o;
    o = pri_order(code);
    return req[o[1:0]] ? o[1:0] : req[o[3:2]] ? o[3:2] : req[o[5:4]] ? o[5:4] : NONE;
  endfunction
  // The two entries other than idx, in their existing relative order, as {later, earlier}.
  function automatic logic [3:0] pri_rest(input logic [2:0] code, input logic [1:0] idx);
    logic [5:0] o;
    o = pri_order(code);
    return (o[1:0] == idx) ? o[5:2] : (o[3:2] == idx) ? {o[5:4], o[1:0]} : o[3:0];
  endfunction
  function automatic logic [2:0] pri_to_head(input logic [2:0] code, input logic [1:0] idx);
    logic [3:0] r;
    r = pri_rest(code, idx);
    return pri_encode(idx, r[1:0], r[3:2]);
  endfunction
  function automatic logic [2:0] pri_to_tail(input logic [2:0] code, input logic [1:0] idx);
    logic [3:0] r;
    r = pri_rest(code, idx);
    return pri_encode(r[1:0], r[3:2], idx);
  endfunction
endpackage

// File: rtl/pri_sched.sv
// pri_sched: requester-order and idle/busy handshake stage with a per-winner burst allowance.
module pri_sched
  import pri_pkg::*;
#(
  parameter int BURST = 4,
  parameter int CNT_W = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       req1,
  input  logic       req2,
  input  logic       req3,
  input  logic       done,
  output logic [2:0] pri,
  output logic       is_idle,
  output logic [2:0] gnt,
  output logic       err_done
);
  state_t r_state, w_state_nxt;
  logic [2:0] r_pri, w_pri_nxt, r_gnt, w_gnt_nxt, w_req;
  logic [CNT_W-1:0] r_run, w_run_nxt, w_n;
  logic [1:0] r_last, w_last_nxt, w_win;
  logic r_idle, r_err, w_err_nxt, w_fire, w_rot;
  assign w_req = {req3, req2, req1};
  assign w_win = pri_winner(r_pri, w_req);
  assign w_fire = (r_state == ST_IDLE) && (w_win != NONE);
  assign w_n = (w_win == r_last) ? r_run + CNT_W'(1) : CNT_W'(1);
  assign w_rot = w_n >= CNT_W'(BURST);
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= ST_IDLE;
      r_idle <= 1'b1;
      r_pri <= P123;
      r_gnt <= 3'b000;
      r_err <= 1'b0;
      r_run <= '0;
      r_last <= NONE;
    end else begin
      r_state <= w_state_nxt;
      r_idle <= (w_state_nxt == ST_IDLE);
      r_pri <= w_pri_nxt;
      r_gnt <= w_gnt_nxt;
      r_err <= w_err_nxt;
      r_run <= w_run_nxt;
      r_last <= w_last_nxt;
    end
  end
  always_comb begin
    w_state_nxt = w_fire ? ST_BUSY : (r_state == ST_BUSY && !done) ? ST_BUSY : ST_IDLE;
  end
  // An exhausted burst sends the winner to the tail and forgets it as the last winner.
  always_comb begin
    w_gnt_nxt = w_fire ? 3'b001 << w_win : 3'b000;
    w_pri_nxt = !w_fire ? r_pri : w_rot ? pri_to_tail(r_pri, w_win) : pri_to_head(r_pri, w_win);
    w_run_nxt = !w_fire ? r_run : w_rot ? '0 : w_n;
    w_last_nxt = !w_fire ? r_last : w_rot ? NONE : w_win;
    w_err_nxt = r_err | (r_state == ST_IDLE && done);
  end
  assign pri = r_pri;
  assign is_idle = r_idle;
  assign gnt = r_gnt;
  assign err_done = r_err;
endmodule
